// File: rtl/mux8_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux8_sched_pkg
// Shared types and helpers for the 8-source round-robin mux scheduler.
//   state_t  : scheduler FSM states (IDLE, GRANT)
//   pick_t   : result of a round-robin search (found flag + winning index)
//   rr_pick  : first set bit of req at or above ptr, wrapping 7 -> 0
// -----------------------------------------------------------------------------
package mux8_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Candidate index wraps naturally in SEL_W bits, so scanning NUM_REQ
  // offsets from ptr visits every source exactly once, starting at ptr.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p.found = 1'b0;
    p.idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux8to1_core.sv
// -----------------------------------------------------------------------------
// mux8to1_core
// Pure combinational 8:1 single-bit multiplexer. Every select code 0..7 is
// routed; there is no out-of-range value.
//   in  [7:0] : data bits, in[i] belongs to source i
//   sel [2:0] : source index
//   out       : in[sel]
// -----------------------------------------------------------------------------
module mux8to1_core
  import mux8_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] in,
  input  logic [SEL_W-1:0]   sel,
  output logic               out
);

  assign out = in[sel];

endmodule

// File: rtl/mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux8_rr_scheduler
// Time-shares one 8:1 bit mux between 8 requesters. Round-robin arbitration
// with a bounded burst: a holder keeps the grant for at most BURST_MAX
// consecutive cycles, then the search restarts just above it.
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   req [7:0] : request vector (level, not latched)
//   in  [7:0] : data bits, in[i] belongs to source i
//   sel [2:0] : index of the current grant holder
//   gnt [7:0] : one-hot grant, zero when idle
//   out       : in[sel] while granted, else 0 (combinational from live in)
//   out_valid : high in every GRANT cycle
//   busy      : copy of out_valid for the status register
// -----------------------------------------------------------------------------
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out,
  output logic               out_valid,
  output logic               busy
);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic               w_exit;
  logic [SEL_W-1:0]   w_search_ptr;
  pick_t              w_pick;
  logic               w_mux_out;
  logic               w_valid;

  // While granted, the search base is the pointer value that an exit would
  // commit (sel+1), so a handover costs no idle cycle.
  always_comb begin
    w_exit       = (!req[r_sel]) || (r_cnt == CNT_W'(BURST_MAX));
    w_search_ptr = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;
    w_pick       = rr_pick(req, w_search_ptr);

    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = r_gnt;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_nxt           = GRANT;
          w_sel_nxt             = w_pick.idx;
          w_gnt_nxt             = '0;
          w_gnt_nxt[w_pick.idx] = 1'b1;
          w_cnt_nxt             = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!w_exit) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_ptr_nxt = w_search_ptr;
          if (w_pick.found) begin
            // A lone requester wraps back to itself and restarts its burst.
            w_sel_nxt             = w_pick.idx;
            w_gnt_nxt             = '0;
            w_gnt_nxt[w_pick.idx] = 1'b1;
            w_cnt_nxt             = CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  mux8to1_core u_mux (
    .in  (in),
    .sel (r_sel),
    .out (w_mux_out)
  );

  assign w_valid   = (r_state == GRANT);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out       = w_mux_out & w_valid;
  assign out_valid = w_valid;
  assign busy      = w_valid;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out;
  logic       out_valid;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  // in = 8'b10101100 -> bit k for k = 0..7
  int exp_cov_out [8] = '{0, 0, 1, 1, 0, 1, 0, 1};

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.BURST_MAX(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (in),
    .sel       (sel),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"},   32'(gnt),       32'h00);
    chk({tag, "_sel"},   32'(sel),       32'h0);
    chk({tag, "_out"},   32'(out),       32'h0);
    chk({tag, "_vld"},   32'(out_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    rst = 1'b0;
    req = 8'h00;
    in  = 8'b10101100;
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("reset");

    step();
    rst = 1'b0;

    // Select coverage: one requester at a time, k = 0..7
    for (int k = 0; k < 8; k++) begin
      req = 8'h01 << k;
      step();
      chk("cov_sel", 32'(sel), 32'(k));
      chk("cov_gnt", 32'(gnt), 32'(8'h01 << k));
      chk("cov_out", 32'(out), 32'(exp_cov_out[k]));
      chk("cov_vld", 32'(out_valid), 32'h1);
      req = 8'h00;
      step();
      chk("cov_idle_gnt", 32'(gnt), 32'h0);
      chk("cov_idle_out", 32'(out), 32'h0);
    end

    // Single holder over-burst: req=8'h20 for 10 cycles, regranted every 4
    req = 8'h20;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("burst_gnt", 32'(gnt), 32'h20);
      chk("burst_out", 32'(out), 32'h1);
      chk("burst_vld", 32'(out_valid), 32'h1);
    end
    req = 8'h00;
    step();
    chk("burst_end_gnt", 32'(gnt), 32'h0);

    // All requesting from reset release: 0..7,0 each for 4 cycles
    rst = 1'b1;
    #1;
    chk_reset_outs("rst2");
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 33; i++) begin
      step();
      chk("all_sel", 32'(sel), 32'((i / 4) % 8));
      chk("all_gnt", 32'(gnt), 32'(8'h01 << ((i / 4) % 8)));
      chk("all_vld", 32'(out_valid), 32'h1);
    end
    req = 8'h00;
    step();
    chk("all_end_gnt", 32'(gnt), 32'h0);

    // Early release: ptr now 1, so 6 wins first; 6 drops after 2 cycles
    req = 8'h41;
    step();
    chk("early_sel1", 32'(sel), 32'h6);
    chk("early_gnt1", 32'(gnt), 32'h40);
    step();
    chk("early_sel2", 32'(sel), 32'h6);
    req = 8'h01;
    step();
    chk("early_wrap_sel", 32'(sel), 32'h0);
    chk("early_wrap_gnt", 32'(gnt), 32'h01);
    chk("early_wrap_vld", 32'(out_valid), 32'h1);
    req = 8'h00;
    step();
    chk("early_end_gnt", 32'(gnt), 32'h0);

    // Idle return: one-cycle pulse on bit 3; out follows live in
    req = 8'h08;
    step();
    chk("pulse_sel", 32'(sel), 32'h3);
    chk("pulse_gnt", 32'(gnt), 32'h08);
    chk("pulse_out", 32'(out), 32'h1);
    in = 8'hF7;
    #1;
    chk("pulse_live_in", 32'(out), 32'h0);
    in = 8'b10101100;
    req = 8'h00;
    step();
    chk("pulse_idle_gnt", 32'(gnt), 32'h0);
    chk("pulse_idle_out", 32'(out), 32'h0);
    chk("pulse_idle_vld", 32'(out_valid), 32'h0);
    chk("pulse_idle_busy", 32'(busy), 32'h0);

    // Reset mid-grant at sel=5, cnt=2
    req = 8'h20;
    step();
    chk("mid_sel1", 32'(sel), 32'h5);
    step();
    chk("mid_sel2", 32'(sel), 32'h5);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    req = 8'hFF;
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_sel", 32'(sel), 32'h0);
    chk("post_rst_gnt", 32'(gnt), 32'h01);
    chk("post_rst_vld", 32'(out_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Time-shares one 8:1 bit mux between 8 requesters using round-robin arbitration with a bounded burst length.
- Drives the mux select, a one-hot grant vector and a qualified serial output bit.
- Sits between the 8 requesting sources and the shared single-bit downstream sink.
- All 8 select codes (0..7) are legal and routed; no select value is treated as out-of-range.

Parameters:
- NUM_REQ, 8: number of requesters. Fixed at 8; the select width is 3.
- BURST_MAX, 4: maximum consecutive granted cycles per grant. Legal range is 1..15.
- CNT_W, 4: burst counter width. Must satisfy 2**CNT_W > BURST_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i] is held high while source i wants the sink.
- in  input  8  data bits; in[i] belongs to source i.
- sel  output  3  mux select; index of the current grant holder.
- gnt  output  8  one-hot grant; all zero when idle.
- out  output  1  in[sel] while granted, else 0.
- out_valid  output  1  high in every GRANT cycle.
- busy  output  1  same as out_valid. Provided for the status register.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, out=0, out_valid=0, busy=0.
- State machine, states IDLE and GRANT.
  - IDLE: if req!=0, search from ptr upward, wrapping 7->0, for the first set bit k. Next cycle: state=GRANT, sel=k, gnt=1<<k, cnt=1. If req==0, stay in IDLE.
  - GRANT: out_valid=1, out=in[sel]. out is combinational from the registered sel and the live in.
    - Exit condition (sampled at the clock edge): req[sel]==0, or cnt==BURST_MAX.
    - No exit: cnt increments and the grant holds.
    - On exit: ptr becomes sel+1 mod 8, and arbitration runs in the same cycle from that new ptr value over the current req.
    - If any req bit is set, the next grant starts on the following cycle with cnt=1 and no idle bubble.
    - If no req bit is set, state goes to IDLE and gnt goes to 0.
- Latency: req rising while in IDLE gives gnt one cycle later.
- Self-regrant: if the exiting holder is the only requester, the search wraps back to it and it is regranted with cnt=1. It is therefore never starved and never exceeds BURST_MAX consecutive cycles per grant.
- Fairness: a continuously requesting source waits at most 7*BURST_MAX cycles between grants.
- A req bit that drops for a non-holder has no effect. req is not latched.
- Invariants: gnt is always zero or one-hot. gnt[sel]==1 whenever out_valid==1. cnt stays within 1..BURST_MAX in GRANT.
- Reset asserted mid-GRANT: outputs go to reset values immediately. After reset release, arbitration restarts from ptr=0.

Decomposition:
- Package mux8_sched_pkg holds:
  - the state enum (IDLE, GRANT);
  - constants NUM_REQ=8 and SEL_W=3;
  - a function rr_pick(req, ptr) that returns the index and a found flag.
- One sub-module, mux8to1_core: a pure combinational 8:1 bit mux with ports in[7:0], sel[2:0], out. It is instanced once; its output is ANDed with out_valid.

Test Plan (in=8'b10101100 unless stated, BURST_MAX=4):
- Select coverage: drive req as a single bit k, for k=0..7 in turn → out sequence 0,0,1,1,0,1,0,1. sel 4..7 must give 0,1,0,1, not 0.
- Single holder over-burst: req=8'h20 held for 10 cycles → gnt=8'h20 continuously, with cnt cycling 1..4, 1..4, 1..2. out=1 throughout and out_valid is never low.
- All requesting: req=8'hFF from reset release → sel sequence 0,1,...,7,0, each held exactly 4 cycles with no bubbles between grants.
- Early release: req=8'h41, with req[6] dropping on its 2nd grant cycle → source 6 holds for 2 cycles, then the grant moves to 0 on the next cycle. ptr must have moved to 7, so the search wraps from 7 to reach 0.
- Idle return: a single request pulse of 1 cycle on bit 3 → one GRANT cycle with sel=3, then IDLE with gnt=0 and out=0.
- Reset mid-grant: assert rst while sel=5 and cnt=2 → all outputs go to 0 without waiting for a clock edge. After release with req=8'hFF, the first grant is sel=0.
